// File: rtl/tdm_demux_if.sv
// Serial TDM link bundle: serial line in, parallel channel registers and status strobes out.
// master drives the serial side; slave is the demultiplexer.
interface tdm_demux_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SLOT_W = 8
);
  logic                       ser_in;
  logic                       ser_vld;
  logic                       fsync;
  logic [NUM_CH*SLOT_W-1:0]   ch_data;
  logic [NUM_CH-1:0]          ch_valid;
  logic                       frame_done;
  logic                       sync_err;
  logic                       locked;

  modport master (
    output ser_in, ser_vld, fsync,
    input  ch_data, ch_valid, frame_done, sync_err, locked
  );

  modport slave (
    input  ser_in, ser_vld, fsync,
    output ch_data, ch_valid, frame_done, sync_err, locked
  );
endinterface

// File: rtl/tdm_demux.sv
// Receive-side TDM demultiplexer: rebuilds NUM_CH MSB-first slots per frame from one serial
// line, with frame-sync hunting, error detection and lock tracking.
module tdm_demux #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SLOT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  tdm_demux_if.slave  bus
);

  localparam int unsigned BitCntW  = $clog2(SLOT_W + 1);
  localparam int unsigned SlotCntW = $clog2(NUM_CH);

  typedef enum logic [0:0] {StHunt, StRecv} state_e;

  state_e                   state_q, state_d;
  logic [SLOT_W-1:0]        shift_q, shift_d;
  logic [BitCntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [SlotCntW-1:0]      slot_cnt_q, slot_cnt_d;
  logic                     expect_sync_q, expect_sync_d;
  logic [NUM_CH*SLOT_W-1:0] ch_data_q, ch_data_d;
  logic [NUM_CH-1:0]        ch_valid_q, ch_valid_d;
  logic                     frame_done_q, frame_done_d;
  logic                     sync_err_q, sync_err_d;
  logic                     locked_q, locked_d;

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    slot_cnt_d    = slot_cnt_q;
    expect_sync_d = expect_sync_q;
    ch_data_d     = ch_data_q;
    ch_valid_d    = '0;
    frame_done_d  = 1'b0;
    sync_err_d    = 1'b0;
    locked_d      = locked_q;

    if (bus.ser_vld) begin
      unique case (state_q)
        StHunt: begin
          if (bus.fsync) begin
            shift_d       = {{(SLOT_W-1){1'b0}}, bus.ser_in};
            bit_cnt_d     = BitCntW'(1);
            slot_cnt_d    = '0;
            expect_sync_d = 1'b0;
            state_d       = StRecv;
          end
        end
        StRecv: begin
          if (expect_sync_q && !bus.fsync) begin
            // Missing frame marker: drop the bit and go re-acquire.
            sync_err_d    = 1'b1;
            locked_d      = 1'b0;
            expect_sync_d = 1'b0;
            bit_cnt_d     = '0;
            slot_cnt_d    = '0;
            shift_d       = '0;
            state_d       = StHunt;
          end else if (bus.fsync) begin
            // Reaching expect_sync implies a full error-free frame just completed.
            sync_err_d    = !expect_sync_q;
            locked_d      = expect_sync_q;
            shift_d       = {{(SLOT_W-1){1'b0}}, bus.ser_in};
            bit_cnt_d     = BitCntW'(1);
            slot_cnt_d    = '0;
            expect_sync_d = 1'b0;
          end else begin
            shift_d = {shift_q[SLOT_W-2:0], bus.ser_in};
            if (bit_cnt_q == BitCntW'(SLOT_W - 1)) begin
              for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (slot_cnt_q == SlotCntW'(k)) begin
                  ch_data_d[k*SLOT_W +: SLOT_W] = shift_d;
                  ch_valid_d[k]                 = 1'b1;
                end
              end
              bit_cnt_d = '0;
              if (slot_cnt_q == SlotCntW'(NUM_CH - 1)) begin
                slot_cnt_d    = '0;
                frame_done_d  = 1'b1;
                expect_sync_d = 1'b1;
              end else begin
                slot_cnt_d = slot_cnt_q + SlotCntW'(1);
              end
            end else begin
              bit_cnt_d = bit_cnt_q + BitCntW'(1);
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StHunt;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      slot_cnt_q    <= '0;
      expect_sync_q <= 1'b0;
      ch_data_q     <= '0;
      ch_valid_q    <= '0;
      frame_done_q  <= 1'b0;
      sync_err_q    <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      slot_cnt_q    <= slot_cnt_d;
      expect_sync_q <= expect_sync_d;
      ch_data_q     <= ch_data_d;
      ch_valid_q    <= ch_valid_d;
      frame_done_q  <= frame_done_d;
      sync_err_q    <= sync_err_d;
      locked_q      <= locked_d;
    end
  end

  assign bus.ch_data    = ch_data_q;
  assign bus.ch_valid   = ch_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.locked     = locked_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux with NUM_CH=4, SLOT_W=8; hand-computed expectations per scenario.
module tb_tdm_demux;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  tdm_demux_if #(.NUM_CH(4), .SLOT_W(8)) bus ();

  tdm_demux #(.NUM_CH(4), .SLOT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs at the falling edge, return 1 time unit after the rising edge.
  task automatic drive(input logic s, input logic f, input logic v);
    @(negedge clk);
    bus.ser_in  = s;
    bus.fsync   = f;
    bus.ser_vld = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.ser_in  = 1'b0;
    bus.fsync   = 1'b0;
    bus.ser_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.ch_data !== 32'h0) begin
      failures++; $display("FAIL reset_ch_data got=%h want=%h", bus.ch_data, 32'h0);
    end
    checks++;
    if (bus.ch_valid !== 4'h0) begin
      failures++; $display("FAIL reset_ch_valid got=%b want=0000", bus.ch_valid);
    end
    checks++;
    if ({bus.frame_done, bus.sync_err, bus.locked} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=000", {bus.frame_done, bus.sync_err, bus.locked});
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Unsynced bits in hunt must be discarded.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b1);
      checks++;
      if (bus.ch_valid !== 4'h0 || bus.sync_err !== 1'b0) begin
        failures++;
        $display("FAIL hunt_discard got valid=%b err=%b want 0000/0", bus.ch_valid, bus.sync_err);
      end
    end
  endtask

  // Sends one 32-bit frame (slot k = fr[8k+:8], MSB first), FSYNC on its first bit.
  task automatic test_frame(input logic [31:0] fr, input bit toggle, input logic lock_exp,
                            input bit err_first, input string name);
    logic [3:0] ev;
    logic       b;
    for (int i = 0; i < 32; i++) begin
      if (toggle) begin
        drive(1'($urandom_range(1)), 1'b1, 1'b0);
        checks++;
        if (bus.ch_valid !== 4'h0 || bus.frame_done !== 1'b0 || bus.sync_err !== 1'b0) begin
          failures++;
          $display("FAIL %s idle%0d got valid=%b fd=%b err=%b want 0000/0/0", name, i,
                   bus.ch_valid, bus.frame_done, bus.sync_err);
        end
      end
      b = fr[(i / 8) * 8 + 7 - (i % 8)];
      drive(b, (i == 0), 1'b1);
      ev = (i % 8 == 7) ? 4'(1 << (i / 8)) : 4'h0;
      checks++;
      if (bus.ch_valid !== ev) begin
        failures++;
        $display("FAIL %s valid bit%0d got=%b want=%b", name, i, bus.ch_valid, ev);
      end
      checks++;
      if (bus.frame_done !== (i == 31)) begin
        failures++;
        $display("FAIL %s frame_done bit%0d got=%b want=%b", name, i, bus.frame_done, (i == 31));
      end
      checks++;
      if (bus.sync_err !== (err_first && i == 0)) begin
        failures++;
        $display("FAIL %s sync_err bit%0d got=%b want=%b", name, i, bus.sync_err,
                 (err_first && i == 0));
      end
      checks++;
      if (bus.locked !== lock_exp) begin
        failures++;
        $display("FAIL %s locked bit%0d got=%b want=%b", name, i, bus.locked, lock_exp);
      end
    end
    checks++;
    if (bus.ch_data !== fr) begin
      failures++; $display("FAIL %s ch_data got=%h want=%h", name, bus.ch_data, fr);
    end
  endtask

  task automatic test_missing_sync();
    drive(1'b1, 1'b0, 1'b1);
    checks++;
    if (bus.sync_err !== 1'b1 || bus.locked !== 1'b0 || bus.ch_valid !== 4'h0) begin
      failures++;
      $display("FAIL missing_sync got err=%b lock=%b valid=%b want 1/0/0000", bus.sync_err,
               bus.locked, bus.ch_valid);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'($urandom_range(1)), 1'b0, 1'b1);
      checks++;
      if (bus.sync_err !== 1'b0 || bus.ch_valid !== 4'h0 || bus.ch_data !== 32'h44332211) begin
        failures++;
        $display("FAIL missing_sync_hunt got err=%b valid=%b data=%h want 0/0000/44332211",
                 bus.sync_err, bus.ch_valid, bus.ch_data);
      end
    end
    test_frame(32'hDEADBEEF, 1'b0, 1'b0, 1'b0, "reacquire");
  endtask

  task automatic test_early_sync();
    logic [31:0] fr;
    fr = 32'h99887766;
    for (int i = 0; i < 19; i++) begin
      drive(fr[(i / 8) * 8 + 7 - (i % 8)], (i == 0), 1'b1);
      if (i == 0) begin
        checks++;
        if (bus.locked !== 1'b1) begin
          failures++; $display("FAIL early_lock_rise got=%b want=1", bus.locked);
        end
      end
    end
    checks++;
    if (bus.ch_data !== 32'hDEAD7766) begin
      failures++; $display("FAIL early_partial got=%h want=%h", bus.ch_data, 32'hDEAD7766);
    end
    test_frame(32'h55AA1234, 1'b0, 1'b0, 1'b1, "early_fresh");
  endtask

  task automatic test_reset_mid();
    logic [31:0] fr;
    fr = 32'h13579BDF;
    for (int i = 0; i < 13; i++) begin
      drive(fr[(i / 8) * 8 + 7 - (i % 8)], (i == 0), 1'b1);
    end
    checks++;
    if (bus.locked !== 1'b1 || bus.ch_data !== 32'h55AA12DF) begin
      failures++;
      $display("FAIL pre_reset got lock=%b data=%h want 1/55aa12df", bus.locked, bus.ch_data);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.ch_data !== 32'h0 || bus.locked !== 1'b0 || bus.ch_valid !== 4'h0) begin
      failures++;
      $display("FAIL mid_reset got data=%h lock=%b valid=%b want 0/0/0", bus.ch_data,
               bus.locked, bus.ch_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b1);
      checks++;
      if (bus.ch_data !== 32'h0 || bus.ch_valid !== 4'h0 || bus.locked !== 1'b0 ||
          bus.sync_err !== 1'b0) begin
        failures++;
        $display("FAIL post_reset got data=%h valid=%b lock=%b err=%b want 0/0/0/0",
                 bus.ch_data, bus.ch_valid, bus.locked, bus.sync_err);
      end
    end
    test_frame(32'h0F0E0D0C, 1'b0, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_frame(32'h00FF3CA5, 1'b0, 1'b0, 1'b0, "first_frame");
    test_frame(32'h44332211, 1'b0, 1'b1, 1'b0, "back_to_back");
    test_frame(32'h44332211, 1'b1, 1'b1, 1'b0, "vld_toggle");
    test_missing_sync();
    test_early_sync();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Receive-side time-division demultiplexer for the serial channel bus. It takes one serial bit line carrying NUM_CH fixed-width slots per frame, with a frame-sync marker on the first bit of each frame. It rebuilds each slot into its own per-channel output register and pulses a per-channel valid strobe when that slot completes. It sits at the far end of the TDM link, where it fans one shared wire back out into parallel channels.

## Interface
- NUM_CH, 4, slots per frame (≥2)
- SLOT_W, 8, bits per slot (≥2), MSB first
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- SER_IN  in  1  serial data bit
- SER_VLD  in  1  SER_IN/FSYNC qualified this cycle; the block ignores both when low
- FSYNC  in  1  high with the first bit (slot 0 MSB) of a frame
- CH_DATA  out  NUM_CH*SLOT_W  channel k occupies bits [k*SLOT_W +: SLOT_W]
- CH_VALID  out  NUM_CH  one-cycle pulse, bit k = channel k updated
- FRAME_DONE  out  1  one-cycle pulse, last slot of a frame completed
- SYNC_ERR  out  1  one-cycle pulse, framing violation detected
- LOCKED  out  1  high after one clean full frame; low otherwise

## Operation
- Reset sets all outputs to 0, state to HUNT, and all counters and the shift register to 0.
- The block samples SER_IN and FSYNC only on edges where SER_VLD=1. Cycles with SER_VLD=0 advance nothing and leave every output strobe low.
- State HUNT:
  - Qualified bits with FSYNC=0 are discarded.
  - A qualified bit with FSYNC=1 is taken as slot 0, bit 0. The shift register loads it, bit_cnt=1, slot_cnt=0, and the state moves to RECV.
- State RECV:
  - Each qualified bit shifts in MSB-first and bit_cnt increments.
  - On the SLOT_W-th bit of a slot, {shift,bit} is written to CH_DATA slot slot_cnt, CH_VALID[slot_cnt] is pulsed, bit_cnt returns to 0, and slot_cnt increments.
  - On slot NUM_CH-1, FRAME_DONE pulses together with CH_VALID[NUM_CH-1], slot_cnt wraps to 0, and an expect_sync flag is set.
- Sync checking in RECV:
  - Qualified bit with expect_sync=1 and FSYNC=1: normal frame start. The bit is taken as bit 0. LOCKED is set to 1 if the frame just completed was a full clean frame.
  - Qualified bit with expect_sync=1 and FSYNC=0: SYNC_ERR pulses, LOCKED goes to 0, the bit is discarded, and the state moves to HUNT.
  - Qualified bit with expect_sync=0 and FSYNC=1 (early or mid-frame sync): SYNC_ERR pulses and LOCKED goes to 0. The partial slot is discarded and the block restarts with this bit as slot 0, bit 0, staying in RECV.
  - Slots already completed in the aborted frame keep their CH_DATA values.
  - The first frame after HUNT never sets LOCKED, even when it completes cleanly. LOCKED rises at the FSYNC that starts the second frame.
- CH_DATA slots hold their value until that slot is rewritten. No output changes on an error except SYNC_ERR and LOCKED.
- RST_N asserted mid-frame clears everything at once. The next frame is acquired from HUNT.

## Timing
- All outputs are registered.
- Latency: CH_DATA[k] and CH_VALID[k] change on the same rising edge that samples the last bit of slot k. Both are visible for the following cycle.
- CH_VALID, FRAME_DONE and SYNC_ERR are high for exactly one cycle per event, regardless of SER_VLD afterwards.
- Minimum frame is NUM_CH*SLOT_W qualified cycles. Back-to-back frames with FSYNC on the very next qualified bit after FRAME_DONE produce no gaps and no errors.
- SYNC_ERR and CH_VALID never pulse on the same edge. The error cases always occur on a bit that does not complete a slot.
- Counter widths are $clog2(SLOT_W+1) and $clog2(NUM_CH).

## Test plan
All scenarios use NUM_CH=4, SLOT_W=8.
- Reset, then one frame of 0xA5,0x3C,0xFF,0x00 with SER_VLD=1 continuously: CH_VALID pulses 0001, 0010, 0100 and 1000 at cycles 8, 16, 24 and 32 after sync. CH_DATA=0x00FF3CA5. FRAME_DONE pulses with 1000. LOCKED stays 0.
- Second frame 0x11,0x22,0x33,0x44 back-to-back: LOCKED rises on that frame's FSYNC bit and SYNC_ERR stays 0. Final CH_DATA=0x44332211.
- Same frame with SER_VLD toggled 1/0 every cycle: identical CH_DATA and strobe order. Strobes land on the edges of the 8th, 16th, 24th and 32nd qualified bits.
- Locked link where FSYNC=0 on the bit after FRAME_DONE: SYNC_ERR pulses once and LOCKED goes to 0. Bits are ignored until the next FSYNC, then the next frame decodes correctly.
- FSYNC reasserted at bit 3 of slot 2: SYNC_ERR pulses and slots 0 and 1 keep their new values. The slot 2 partial is dropped, and the following 32 bits decode as a fresh frame.
- RST_N pulsed low at bit 5 of slot 1: all outputs read 0 during and after reset. Bits before the next FSYNC are ignored.
